// File: rtl/psram_pixel_fetch_pkg.sv
// -----------------------------------------------------------------------------
// psram_pixel_fetch_pkg
//   Shared definitions for the cellular-RAM pixel fetch path:
//   - fetch_state_t : FSM state encodings (IDLE, ACCESS)
//   - DEF_*         : default read wait and address widths
//   - *_BASE_WORD   : image base-word constants used by the address generator
//   - cnt_width()   : width of a counter that must reach read_wait-1
// -----------------------------------------------------------------------------
package psram_pixel_fetch_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } fetch_state_t;

    localparam int DEF_READ_WAIT = 3;
    localparam int DEF_MEM_AW    = 23;
    localparam int DEF_REQ_AW    = 26;

    // Word offsets of the image regions inside the cellular RAM.
    localparam logic [DEF_MEM_AW-1:0] TITLE_BASE_WORD  = 23'h000000;
    localparam logic [DEF_MEM_AW-1:0] LEVEL_BASE_WORD  = 23'h04B000;
    localparam logic [DEF_MEM_AW-1:0] SPRITE_BASE_WORD = 23'h200000;

    // A read_wait of 1 still needs a 1-bit counter.
    function automatic int cnt_width(input int read_wait);
        return (read_wait > 1) ? $clog2(read_wait) : 1;
    endfunction

endpackage

// File: rtl/psram_pixel_fetch.sv
// -----------------------------------------------------------------------------
// psram_pixel_fetch
//   Read-only fetch engine between the sprite/background address generator and
//   the 16-bit asynchronous cellular RAM. A one-cycle req starts a read that
//   holds CE/OE low for READ_WAIT cycles, then samples mem_data into mem_value
//   and pulses valid. Requests arriving while busy are dropped (overrun), and
//   accepted addresses with bits above MEM_AW-1 set raise addr_err.
//
// Build option:
//   FETCH_CACHE_EN - remember the last completed word address; a matching req
//                    in IDLE skips the RAM cycle and pulses valid next cycle.
//
// Ports:
//   clk_50Mhz  in   sole clock, rising edge
//   rst        in   synchronous, active-high reset
//   req        in   1-cycle strobe, rom_addr sampled with it
//   rom_addr   in   [REQ_AW-1:0] word address to read
//   busy       out  RAM cycle in flight
//   valid      out  1-cycle pulse, mem_value updated
//   mem_value  out  [15:0] last word read
//   overrun    out  sticky, a req was dropped while busy
//   addr_err   out  sticky, an accepted address was out of range
//   mem_addr   out  [MEM_AW-1:0] registered RAM address
//   mem_ce_n   out  RAM chip enable (active low)
//   mem_oe_n   out  RAM output enable (active low)
//   mem_we_n   out  RAM write enable, tied high
//   mem_adv_n  out  RAM address valid, tied high (async mode)
//   mem_data   in   [15:0] RAM data bus
// -----------------------------------------------------------------------------
module psram_pixel_fetch
    import psram_pixel_fetch_pkg::*;
#(
    parameter int READ_WAIT = DEF_READ_WAIT,
    parameter int MEM_AW    = DEF_MEM_AW,
    parameter int REQ_AW    = DEF_REQ_AW    // must be larger than MEM_AW
) (
    input  logic              clk_50Mhz,
    input  logic              rst,
    input  logic              req,
    input  logic [REQ_AW-1:0] rom_addr,
    output logic              busy,
    output logic              valid,
    output logic [15:0]       mem_value,
    output logic              overrun,
    output logic              addr_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              mem_adv_n,
    input  logic [15:0]       mem_data
);

    localparam int CW = cnt_width(READ_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_WAIT - 1);

    fetch_state_t      state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              busy_nxt, valid_nxt, overrun_nxt, addr_err_nxt;
    logic [15:0]       value_nxt;
    logic [MEM_AW-1:0] addr_nxt;
    logic              strobe_n, strobe_n_nxt;   // shared CE/OE level
    logic              done;                     // completion edge of a RAM read
    logic              cache_hit;

    assign mem_ce_n  = strobe_n;
    assign mem_oe_n  = strobe_n;
    assign mem_we_n  = 1'b1;
    assign mem_adv_n = 1'b1;

    assign done = (state == ST_ACCESS) && (cnt == CNT_LAST);

`ifdef FETCH_CACHE_EN
    logic cache_ok;

    // mem_addr only changes when a RAM read starts, so while idle it holds the
    // last completed word address; comparing the truncated address is exact
    // because the RAM itself never sees the upper request bits.
    assign cache_hit = cache_ok && (rom_addr[MEM_AW-1:0] == mem_addr);

    always_ff @(posedge clk_50Mhz) begin
        if (rst)
            cache_ok <= 1'b0;
        else if (done)
            cache_ok <= 1'b1;
    end
`else
    assign cache_hit = 1'b0;
`endif

    // NOTE: every *_nxt gets a default before the case so no path leaves a
    // variable unassigned; a missing default here infers a latch.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        busy_nxt     = busy;
        valid_nxt    = 1'b0;
        value_nxt    = mem_value;
        overrun_nxt  = overrun;
        addr_err_nxt = addr_err;
        addr_nxt     = mem_addr;
        strobe_n_nxt = strobe_n;

        unique case (state)
            ST_IDLE: begin
                if (req) begin
                    if (|rom_addr[REQ_AW-1:MEM_AW])
                        addr_err_nxt = 1'b1;
                    if (cache_hit) begin
                        valid_nxt = 1'b1;
                    end else begin
                        addr_nxt     = rom_addr[MEM_AW-1:0];
                        strobe_n_nxt = 1'b0;
                        busy_nxt     = 1'b1;
                        cnt_nxt      = '0;
                        state_nxt    = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (req)
                    overrun_nxt = 1'b1;
                if (done) begin
                    value_nxt    = mem_data;
                    valid_nxt    = 1'b1;
                    strobe_n_nxt = 1'b1;
                    busy_nxt     = 1'b0;
                    state_nxt    = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            mem_value <= '0;
            overrun   <= 1'b0;
            addr_err  <= 1'b0;
            mem_addr  <= '0;
            strobe_n  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            busy      <= busy_nxt;
            valid     <= valid_nxt;
            mem_value <= value_nxt;
            overrun   <= overrun_nxt;
            addr_err  <= addr_err_nxt;
            mem_addr  <= addr_nxt;
            strobe_n  <= strobe_n_nxt;
        end
    end

endmodule

// File: tb/tb_psram_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_psram_pixel_fetch
//   Bench for psram_pixel_fetch. A RAM model answers with a fixed function of
//   the address while CE/OE are low. A reference model tracks the request
//   timeline in absolute edge numbers (when the current read ends, what value
//   it returns) and every cycle all outputs are compared with it. A table of
//   isolated reads, hand-written corner sequences and a random run follow.
//   Honors FETCH_CACHE_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_psram_pixel_fetch;

    localparam int RW  = 3;
    localparam int MAW = 23;
    localparam int RAW = 26;

    logic            clk_50Mhz = 1'b0;
    logic            rst, req;
    logic [RAW-1:0]  rom_addr;
    logic            busy, valid, overrun, addr_err;
    logic [15:0]     mem_value, mem_data;
    logic [MAW-1:0]  mem_addr;
    logic            mem_ce_n, mem_oe_n, mem_we_n, mem_adv_n;

    always #10 clk_50Mhz = ~clk_50Mhz;

    psram_pixel_fetch #(.READ_WAIT(RW), .MEM_AW(MAW), .REQ_AW(RAW)) dut (
        .clk_50Mhz (clk_50Mhz),
        .rst       (rst),
        .req       (req),
        .rom_addr  (rom_addr),
        .busy      (busy),
        .valid     (valid),
        .mem_value (mem_value),
        .overrun   (overrun),
        .addr_err  (addr_err),
        .mem_addr  (mem_addr),
        .mem_ce_n  (mem_ce_n),
        .mem_oe_n  (mem_oe_n),
        .mem_we_n  (mem_we_n),
        .mem_adv_n (mem_adv_n),
        .mem_data  (mem_data)
    );

    // RAM contents: a fixed function of the word address.
    function automatic logic [15:0] mem_fn(input logic [MAW-1:0] a);
        return a[15:0] ^ 16'hA4CF ^ {9'b0, a[22:16]};
    endfunction

    // Garbage while the RAM is not selected.
    assign mem_data = (!mem_ce_n && !mem_oe_n) ? mem_fn(mem_addr) : 16'hF00D;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: timeline in absolute clock-edge numbers.
    int             k_edge   = 0;
    int             busy_end = -10;   // edge at which the current read completes
    bit             pending  = 1'b0;  // RAM read in flight
    logic [MAW-1:0] pend_addr = '0;
    bit             cache_ok = 1'b0;
    logic [MAW-1:0] cache_addr = '0;
    logic           e_valid = 1'b0, e_overrun = 1'b0, e_err = 1'b0;
    logic [15:0]    e_value = '0;
    logic [MAW-1:0] e_maddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, k_edge, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic q, input logic [RAW-1:0] a);
        bit hit;
        k_edge++;
        if (r) begin
            busy_end = -10; pending = 1'b0; cache_ok = 1'b0;
            e_valid = 1'b0; e_overrun = 1'b0; e_err = 1'b0;
            e_value = '0; e_maddr = '0;
            return;
        end
        e_valid = 1'b0;
        if (pending && k_edge == busy_end) begin
            e_value    = mem_fn(pend_addr);
            e_valid    = 1'b1;
            pending    = 1'b0;
            cache_ok   = 1'b1;
            cache_addr = pend_addr;
        end
        if (q) begin
            if (k_edge <= busy_end) begin
                e_overrun = 1'b1;
            end else begin
                if (a[RAW-1:MAW] != 0) e_err = 1'b1;
                hit = 1'b0;
`ifdef FETCH_CACHE_EN
                hit = cache_ok && (a[MAW-1:0] == cache_addr);
`endif
                if (hit) begin
                    e_valid  = 1'b1;
                    busy_end = k_edge;
                end else begin
                    e_maddr   = a[MAW-1:0];
                    pend_addr = a[MAW-1:0];
                    pending   = 1'b1;
                    busy_end  = k_edge + RW;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic e_busy;
        e_busy = (k_edge < busy_end);
        check("valid",     32'(valid),     32'(e_valid));
        check("busy",      32'(busy),      32'(e_busy));
        check("mem_ce_n",  32'(mem_ce_n),  32'(!e_busy));
        check("mem_oe_n",  32'(mem_oe_n),  32'(!e_busy));
        check("mem_we_n",  32'(mem_we_n),  32'd1);
        check("mem_adv_n", 32'(mem_adv_n), 32'd1);
        check("mem_value", 32'(mem_value), 32'(e_value));
        check("mem_addr",  32'(mem_addr),  32'(e_maddr));
        check("overrun",   32'(overrun),   32'(e_overrun));
        check("addr_err",  32'(addr_err),  32'(e_err));
    endtask

    // One clock: drive, let the edge happen, advance the model, compare on the
    // falling edge.
    task automatic cycle(input logic r, input logic q, input logic [RAW-1:0] a);
        rst = r; req = q; rom_addr = a;
        @(posedge clk_50Mhz);
        model_step(r, q, a);
        @(negedge clk_50Mhz);
        compare_all();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, '0);
    endtask

    typedef struct {
        logic [RAW-1:0] addr;
        logic [MAW-1:0] exp_maddr;
        logic [15:0]    exp_value;
        logic           exp_err;    // sticky flag after this read
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{26'h000012C, 23'h00012C, 16'hA5E3, 1'b0};
        vecs[1] = '{26'h0000000, 23'h000000, 16'hA4CF, 1'b0};
        vecs[2] = '{26'h0001234, 23'h001234, 16'hB6FB, 1'b0};
        vecs[3] = '{26'h07FFFFF, 23'h7FFFFF, 16'h5B4F, 1'b0};
        vecs[4] = '{26'h0800010, 23'h000010, 16'hA4DF, 1'b1};
        vecs[5] = '{26'h3FFFFFF, 23'h7FFFFF, 16'h5B4F, 1'b1};

        rst = 1'b1; req = 1'b0; rom_addr = '0;
        @(negedge clk_50Mhz);

        // Reset held three cycles, requests ignored meanwhile.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, (i == 1), 26'h0000055);
            check("rst_ce_n", 32'(mem_ce_n), 32'd1);
            check("rst_valid", 32'(valid), 32'd0);
        end

        // Isolated reads from the table.
        foreach (vecs[v]) begin
            cycle(1'b0, 1'b1, vecs[v].addr);
            check("tbl_ce_low_t1", 32'(mem_ce_n), 32'd0);
            for (int i = 0; i < RW; i++) begin
                cycle(1'b0, 1'b0, '0);
                if (i < RW - 1)
                    check("tbl_ce_low", 32'(mem_ce_n), 32'd0);
            end
            check("tbl_valid", 32'(valid), 32'd1);
            check("tbl_busy", 32'(busy), 32'd0);
            check("tbl_ce_high", 32'(mem_ce_n), 32'd1);
            check("tbl_value", 32'(mem_value), 32'(vecs[v].exp_value));
            check("tbl_maddr", 32'(mem_addr), 32'(vecs[v].exp_maddr));
            check("tbl_err", 32'(addr_err), 32'(vecs[v].exp_err));
            cycle(1'b0, 1'b0, '0);
            check("tbl_valid_1cyc", 32'(valid), 32'd0);
            check("tbl_value_hold", 32'(mem_value), 32'(vecs[v].exp_value));
        end

        // Drop while busy, then accept in the valid cycle.
        do_reset();
        cycle(1'b0, 1'b1, 26'h0000040);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 26'h0000041);
        check("ovr_set", 32'(overrun), 32'd1);
        cycle(1'b0, 1'b0, '0);
        check("ovr_valid", 32'(valid), 32'd1);
        check("ovr_value", 32'(mem_value), 32'hA48F);
        cycle(1'b0, 1'b1, 26'h0000044);
        check("ovr_accept_busy", 32'(busy), 32'd1);
        check("ovr_accept_addr", 32'(mem_addr), 32'h44);
        for (int i = 0; i < RW; i++) cycle(1'b0, 1'b0, '0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_value2", 32'(mem_value), 32'hA48B);

        // Reset in the middle of a read aborts it with no valid pulse.
        do_reset();
        cycle(1'b0, 1'b1, 26'h0000077);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        check("abort_ce_n", 32'(mem_ce_n), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < RW + 2; i++) begin
            cycle(1'b0, 1'b0, '0);
            check("abort_no_valid", 32'(valid), 32'd0);
        end
        check("abort_value", 32'(mem_value), 32'd0);

        // Same word twice, then its neighbour.
        do_reset();
        cycle(1'b0, 1'b1, 26'h00004B0);
        for (int i = 0; i < RW; i++) cycle(1'b0, 1'b0, '0);
        check("rep_first_value", 32'(mem_value), 32'hA07F);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 26'h00004B0);
`ifdef FETCH_CACHE_EN
        check("hit_valid", 32'(valid), 32'd1);
        check("hit_no_ce", 32'(mem_ce_n), 32'd1);
        check("hit_value", 32'(mem_value), 32'hA07F);
`else
        check("rep_full_ce", 32'(mem_ce_n), 32'd0);
        for (int i = 0; i < RW; i++) cycle(1'b0, 1'b0, '0);
        check("rep_valid", 32'(valid), 32'd1);
`endif
        cycle(1'b0, 1'b1, 26'h00004B1);
        check("next_word_ce", 32'(mem_ce_n), 32'd0);
        for (int i = 0; i < RW; i++) cycle(1'b0, 1'b0, '0);
        check("next_word_value", 32'(mem_value), 32'hA07E);

        // Random traffic with occasional resets and out-of-range addresses.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic           r, q;
            logic [RAW-1:0] a;
            r = ($urandom_range(0, 199) == 0);
            q = ($urandom_range(0, 9) < 4);
            a[MAW-1:0] = ($urandom_range(0, 3) == 0) ? MAW'($urandom) : MAW'($urandom_range(0, 5));
            a[RAW-1:MAW] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            cycle(r, q, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
